mef_arb_ctrl: RTL and testbench

Controller that shares one serial finite-state-machine detector (input E, output Y, clear CLR) between two requesters. It arbitrates round-robin and latches the winner's WIDTH-bit word. It clears the detector, serialises the word MSB-first onto the detector's E input, and counts detector hits, reporting a saturating COUNT with a one-cycle DONE pulse. It sits between the requesting blocks and the detector instance.

---
 rtl/mef_arb_ctrl.sv | 120 ++++++++++++
 tb/tb_mef_arb_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mef_arb_ctrl.sv
// Round-robin front end for a shared serial detector: grants one of two requesters,
// clears the detector, shifts the winner's word out MSB-first and counts detector hits.
module mef_arb_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNTW  = 4
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             REQ0,
  input  logic             REQ1,
  input  logic [WIDTH-1:0] DATA0,
  input  logic [WIDTH-1:0] DATA1,
  output logic             GNT0,
  output logic             GNT1,
  output logic             E_OUT,
  output logic             DET_CLR,
  input  logic             Y_IN,
  output logic             BUSY,
  output logic             DONE,
  output logic             OWNER,
  output logic [CNTW-1:0]  COUNT
);

  localparam int BW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0]   LAST_BIT = BW'(WIDTH - 1);
  localparam logic [CNTW-1:0] CNT_MAX  = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_SHIFT,
    ST_FLUSH,
    ST_DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shift_reg;
  logic [BW-1:0]    bit_cnt;
  logic             prio;
  logic             any_req;
  logic             pick1;
  logic [CNTW-1:0]  count_next;

  // prio=1 favours REQ1; a lone requester wins regardless of prio
  assign any_req = REQ0 | REQ1;
  assign pick1   = REQ1 & (~REQ0 | prio);

  always_comb begin
    count_next = COUNT;
    if (Y_IN && (COUNT != CNT_MAX)) count_next = COUNT + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state     <= ST_IDLE;
      GNT0      <= 1'b0;
      GNT1      <= 1'b0;
      E_OUT     <= 1'b0;
      DET_CLR   <= 1'b1;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      OWNER     <= 1'b0;
      COUNT     <= '0;
      prio      <= 1'b0;
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else begin
      GNT0    <= 1'b0;
      GNT1    <= 1'b0;
      DET_CLR <= 1'b0;
      DONE    <= 1'b0;
      E_OUT   <= 1'b0;
      BUSY    <= 1'b0;
      case (state)
        // The DONE cycle arbitrates like IDLE so a waiting requester is granted right after DONE
        ST_IDLE, ST_DONE: begin
          if (any_req) begin
            state     <= ST_CLEAR;
            OWNER     <= pick1;
            prio      <= ~pick1;
            shift_reg <= pick1 ? DATA1 : DATA0;
            GNT0      <= ~pick1;
            GNT1      <= pick1;
            DET_CLR   <= 1'b1;
            BUSY      <= 1'b1;
            COUNT     <= '0;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_CLEAR: begin
          state     <= ST_SHIFT;
          bit_cnt   <= '0;
          E_OUT     <= shift_reg[WIDTH-1];
          shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
          BUSY      <= 1'b1;
        end
        ST_SHIFT: begin
          // The cycle-0 sample still reflects the detector before this job
          if (bit_cnt != '0) COUNT <= count_next;
          BUSY <= 1'b1;
          if (bit_cnt == LAST_BIT) begin
            state <= ST_FLUSH;
          end else begin
            bit_cnt   <= bit_cnt + 1'b1;
            E_OUT     <= shift_reg[WIDTH-1];
            shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
          end
        end
        ST_FLUSH: begin
          COUNT <= count_next;
          state <= ST_DONE;
          DONE  <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mef_arb_ctrl.sv
// Scoreboard bench for mef_arb_ctrl: stimulus queues expected jobs, a negedge
// monitor checks grants, the serial word and the DONE result against them.
module tb_mef_arb_ctrl;

  localparam int WIDTH = 8;
  localparam int CNTW  = 3;

  logic             CLK = 1'b0;
  logic             CLR;
  logic             REQ0, REQ1;
  logic [WIDTH-1:0] DATA0, DATA1;
  logic             GNT0, GNT1, E_OUT, DET_CLR, Y_IN, BUSY, DONE, OWNER;
  logic [CNTW-1:0]  COUNT;

  typedef struct {
    logic            owner;
    logic [WIDTH-1:0] word;
    logic [CNTW-1:0] count;
    int              gnt_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   done_total = 0;

  mef_arb_ctrl #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
    .CLK(CLK), .CLR(CLR), .REQ0(REQ0), .REQ1(REQ1), .DATA0(DATA0), .DATA1(DATA1),
    .GNT0(GNT0), .GNT1(GNT1), .E_OUT(E_OUT), .DET_CLR(DET_CLR), .Y_IN(Y_IN),
    .BUSY(BUSY), .DONE(DONE), .OWNER(OWNER), .COUNT(COUNT)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: grant, serial word and DONE result checked against the queue head
  logic [WIDTH-1:0] cap_word;
  int               cap_n = 0;
  bit               capturing = 1'b0;
  int               gnt_seen_cyc = 0;

  always @(negedge CLK) begin
    exp_t e;
    if (CLR) begin
      capturing = 1'b0;
      cap_n     = 0;
    end else begin
      if (capturing) begin
        cap_word = {cap_word[WIDTH-2:0], E_OUT};
        cap_n++;
        if (cap_n == WIDTH) begin
          capturing = 1'b0;
          if (exp_q.size() > 0) checkOutput("serial_word", 32'(cap_word), 32'(exp_q[0].word));
        end
      end
      if (GNT0 || GNT1) begin
        gnt_seen_cyc = cyc;
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_grant", 32'd1, 32'd0);
        end else begin
          checkOutput("grant_owner", {30'd0, GNT1, GNT0}, exp_q[0].owner ? 32'd2 : 32'd1);
          checkOutput("grant_cycle", 32'(cyc), 32'(exp_q[0].gnt_cyc));
          checkOutput("det_clr_at_grant", {31'd0, DET_CLR}, 32'd1);
          checkOutput("busy_at_grant", {31'd0, BUSY}, 32'd1);
          checkOutput("e_out_in_clear", {31'd0, E_OUT}, 32'd0);
        end
        capturing = 1'b1;
        cap_n     = 0;
        cap_word  = '0;
      end
      if (DONE) begin
        done_total++;
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("done_owner", {31'd0, OWNER}, {31'd0, e.owner});
          checkOutput("done_count", 32'(COUNT), 32'(e.count));
          checkOutput("done_latency", 32'(cyc - gnt_seen_cyc), 32'(WIDTH + 2));
          checkOutput("busy_at_done", {31'd0, BUSY}, 32'd0);
        end
      end
    end
  end

  task automatic waitGrant(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge CLK);
      if (GNT0 || GNT1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checkOutput("grant_timeout", 32'd0, 32'd1);
      exp_q.delete();
      REQ0 = 1'b0;
      REQ1 = 1'b0;
    end
  endtask

  // Called just after a rising edge; returns just after the edge that enters DONE
  task automatic applyStimulus(input logic r0, input logic r1,
                               input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1,
                               input logic [WIDTH:0] ypat, input logic eown,
                               input logic [CNTW-1:0] ecnt);
    exp_t e;
    bit   ok;
    e.owner   = eown;
    e.word    = eown ? d1 : d0;
    e.count   = ecnt;
    e.gnt_cyc = cyc + 1;
    exp_q.push_back(e);
    REQ0  = r0;
    REQ1  = r1;
    DATA0 = d0;
    DATA1 = d1;
    waitGrant(ok);
    if (!ok) return;
    @(posedge CLK) #1;
    if (eown) REQ1 = 1'b0;
    else      REQ0 = 1'b0;
    for (int k = 0; k <= WIDTH; k++) begin
      Y_IN = ypat[k];
      @(posedge CLK) #1;
    end
    Y_IN = 1'b0;
  endtask

  initial begin
    exp_t e;
    bit   ok;
    int   snap;
    CLR   = 1'b1;
    REQ0  = 1'b0;
    REQ1  = 1'b0;
    DATA0 = '0;
    DATA1 = '0;
    Y_IN  = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    checkOutput("rst_det_clr", {31'd0, DET_CLR}, 32'd1);
    checkOutput("rst_busy", {31'd0, BUSY}, 32'd0);
    checkOutput("rst_gnt", {30'd0, GNT1, GNT0}, 32'd0);
    checkOutput("rst_done", {31'd0, DONE}, 32'd0);
    checkOutput("rst_e_out", {31'd0, E_OUT}, 32'd0);
    checkOutput("rst_owner", {31'd0, OWNER}, 32'd0);
    checkOutput("rst_count", 32'(COUNT), 32'd0);
    CLR = 1'b0;
    @(posedge CLK) #1;
    checkOutput("idle_det_clr", {31'd0, DET_CLR}, 32'd0);
    checkOutput("idle_busy", {31'd0, BUSY}, 32'd0);
    @(posedge CLK) #1;

    applyStimulus(1, 0, 8'hB1, 8'h00, 9'b0_0000_0000, 0, 3'd0);
    @(posedge CLK) #1;
    applyStimulus(1, 0, 8'h5A, 8'h00, 9'b1_0100_1000, 0, 3'd3);
    @(posedge CLK) #1;
    applyStimulus(0, 1, 8'h00, 8'h3C, 9'b0_0000_0001, 1, 3'd0);
    @(posedge CLK) #1;
    applyStimulus(0, 1, 8'h00, 8'hFF, 9'b1_1111_1111, 1, 3'd7);
    @(posedge CLK) #1;

    $display("[TB] arbitration with both requesters held");
    applyStimulus(1, 1, 8'hA5, 8'h96, 9'b0_0000_0010, 0, 3'd1);
    applyStimulus(1, 1, 8'hC3, 8'h96, 9'b1_0000_0000, 1, 3'd1);
    applyStimulus(1, 1, 8'hC3, 8'h96, 9'b0_0000_0000, 0, 3'd0);
    REQ1 = 1'b0;
    repeat (3) @(posedge CLK);
    #1;

    $display("[TB] reset in the middle of a job");
    e.owner   = 1'b0;
    e.word    = 8'h77;
    e.count   = '0;
    e.gnt_cyc = cyc + 1;
    exp_q.push_back(e);
    REQ0  = 1'b1;
    DATA0 = 8'h77;
    Y_IN  = 1'b1;
    waitGrant(ok);
    @(posedge CLK) #1;
    REQ0 = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    CLR = 1'b1;
    exp_q.delete();
    @(posedge CLK) #1;
    CLR  = 1'b0;
    Y_IN = 1'b0;
    @(negedge CLK);
    checkOutput("clr_busy", {31'd0, BUSY}, 32'd0);
    checkOutput("clr_count", 32'(COUNT), 32'd0);
    checkOutput("clr_done", {31'd0, DONE}, 32'd0);
    checkOutput("clr_e_out", {31'd0, E_OUT}, 32'd0);
    snap = done_total;
    repeat (12) @(negedge CLK);
    checkOutput("no_done_after_clr", 32'(done_total - snap), 32'd0);
    @(posedge CLK) #1;
    applyStimulus(1, 1, 8'h4E, 8'h21, 9'b0_0000_0100, 0, 3'd1);
    REQ1 = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
